dstack_ctrl: RTL

- Data-stack controller for the Forth core.
- Holds top-of-stack (TOS) in a register and tracks stack depth.
- Translates core stack ops into the we/delta/wd command stream of the RAM-backed stack that sits directly downstream; that stack's read word (NOS) is returned on stk_rd.
- Detects overflow/underflow, suppresses the faulting op and raises sticky error flags.

---
 rtl/dstack_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/dstack_ctrl.sv
// dstack_ctrl -- data-stack controller for the Forth core.
// Holds top-of-stack in a register and tracks stack depth. Core stack ops are
// translated into the we/delta/wd command stream of the RAM-backed stack that
// sits downstream; that stack's read word (NOS) comes back on stk_rd.
// Over/underflowing ops are suppressed completely and raise sticky flags.

module dstack_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512,
  localparam int DW = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic             stk_we,
  output logic [1:0]       stk_delta,
  output logic [WIDTH-1:0] stk_wd,
  input  logic [WIDTH-1:0] stk_rd,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [DW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  // Op encoding used by the core.
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_DROP  = 3'd2;
  localparam logic [2:0] OP_LOAD  = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_DUP   = 3'd5;
  localparam logic [2:0] OP_OVER  = 3'd6;
  localparam logic [2:0] OP_NIPLD = 3'd7;

  // Pointer movement commands for the RAM stack (2-bit two's complement).
  localparam logic [1:0] DELTA_HOLD = 2'b00;
  localparam logic [1:0] DELTA_INC  = 2'b01;
  localparam logic [1:0] DELTA_DEC  = 2'b11;

  // Depth constants; capacity is the RAM entries plus the TOS register.
  localparam logic [DW-1:0] D_ZERO = DW'(0);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [DW-1:0] D_TWO  = DW'(2);
  localparam logic [DW-1:0] D_MAX  = DW'(DEPTH + 1);

  // Op needs more items than the stack currently holds.
  function automatic logic f_underflow(input logic [2:0] op_f,
                                       input logic [DW-1:0] depth_f);
    logic hit;
    hit = 1'b0;
    case (op_f)
      OP_DROP, OP_LOAD, OP_DUP:    hit = (depth_f == D_ZERO);
      OP_SWAP, OP_OVER, OP_NIPLD:  hit = (depth_f < D_TWO);
      default:                     hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Op would grow a stack that is already at full capacity.
  function automatic logic f_overflow(input logic [2:0] op_f,
                                      input logic [DW-1:0] depth_f);
    logic hit;
    hit = 1'b0;
    case (op_f)
      OP_PUSH, OP_DUP, OP_OVER: hit = (depth_f == D_MAX);
      default:                  hit = 1'b0;
    endcase
    return hit;
  endfunction

  logic [WIDTH-1:0] tos_r;
  logic [DW-1:0]    depth_r;
  logic             ovf_r;
  logic             unf_r;

  logic [2:0]       op_s;
  logic             unf_hit_s;
  logic             ovf_hit_s;
  logic             we_s;
  logic [1:0]       delta_s;
  logic [WIDTH-1:0] tos_nxt_s;
  logic [DW-1:0]    depth_nxt_s;

  // Decode the op into the RAM command and the next TOS/depth.
  always_comb begin
    op_s        = op_valid ? op : OP_NOP;
    unf_hit_s   = f_underflow(op_s, depth_r);
    ovf_hit_s   = f_overflow(op_s, depth_r);
    we_s        = 1'b0;
    delta_s     = DELTA_HOLD;
    tos_nxt_s   = tos_r;
    depth_nxt_s = depth_r;
    if (unf_hit_s || ovf_hit_s) begin
      // Faulting op leaves the stack and RAM untouched.
      we_s        = 1'b0;
      delta_s     = DELTA_HOLD;
      tos_nxt_s   = tos_r;
      depth_nxt_s = depth_r;
    end else begin
      case (op_s)
        OP_PUSH: begin
          tos_nxt_s   = din;
          depth_nxt_s = depth_r + D_ONE;
          if (depth_r == D_ZERO) begin
            // First item lives only in TOS; nothing to spill.
            we_s    = 1'b0;
            delta_s = DELTA_HOLD;
          end else begin
            we_s    = 1'b1;
            delta_s = DELTA_INC;
          end
        end
        OP_DROP: begin
          depth_nxt_s = depth_r - D_ONE;
          if (depth_r == D_ONE) begin
            // Last item leaves TOS; RAM holds nothing to pop.
            we_s      = 1'b0;
            delta_s   = DELTA_HOLD;
            tos_nxt_s = '0;
          end else begin
            we_s      = 1'b0;
            delta_s   = DELTA_DEC;
            tos_nxt_s = stk_rd;
          end
        end
        OP_LOAD: begin
          we_s      = 1'b0;
          delta_s   = DELTA_HOLD;
          tos_nxt_s = din;
        end
        OP_SWAP: begin
          // Old TOS overwrites the NOS slot in place.
          we_s      = 1'b1;
          delta_s   = DELTA_HOLD;
          tos_nxt_s = stk_rd;
        end
        OP_DUP: begin
          we_s        = 1'b1;
          delta_s     = DELTA_INC;
          depth_nxt_s = depth_r + D_ONE;
        end
        OP_OVER: begin
          we_s        = 1'b1;
          delta_s     = DELTA_INC;
          tos_nxt_s   = stk_rd;
          depth_nxt_s = depth_r + D_ONE;
        end
        OP_NIPLD: begin
          // Binary ALU result replaces TOS and NOS.
          tos_nxt_s   = din;
          depth_nxt_s = depth_r - D_ONE;
          if (depth_r == D_ONE) begin
            we_s    = 1'b0;
            delta_s = DELTA_HOLD;
          end else begin
            we_s    = 1'b0;
            delta_s = DELTA_DEC;
          end
        end
        default: begin
          we_s        = 1'b0;
          delta_s     = DELTA_HOLD;
          tos_nxt_s   = tos_r;
          depth_nxt_s = depth_r;
        end
      endcase
    end
  end

  // TOS and depth registers; reset is shared with the RAM stack pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_r   <= '0;
      depth_r <= D_ZERO;
    end else begin
      tos_r   <= tos_nxt_s;
      depth_r <= depth_nxt_s;
    end
  end

  // Sticky error flags; a fault in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_hit_s | (ovf_r & ~clr_err);
      unf_r <= unf_hit_s | (unf_r & ~clr_err);
    end
  end

  // RAM commands are quiet while reset is asserted.
  assign stk_we    = rst_n & we_s;
  assign stk_delta = rst_n ? delta_s : DELTA_HOLD;
  assign stk_wd    = tos_r;

  assign tos   = tos_r;
  assign nos   = stk_rd;
  assign depth = depth_r;
  assign empty = (depth_r == D_ZERO);
  assign full  = (depth_r == D_MAX);
  assign ovf   = ovf_r;
  assign unf   = unf_r;

endmodule
